// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the shared-timer debouncer.
// Holds the arbiter FSM state encoding and the default timer width.

package debounce_pkg;

    // Default width of the shared stability timer and of final_value.
    localparam int DEB_TIMER_BITS_DEFAULT = 18;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_COMMIT = 2'd2
    } deb_state_e;

endpackage : debounce_pkg

// File: rtl/deb_shared_timer.sv
// deb_shared_timer: stability counter shared by all debounce channels.
// Counts up from zero while enabled and stops at the latched terminal value,
// so it never wraps. done_o is high while the count equals the terminal value.

module deb_shared_timer
    import debounce_pkg::*;
#(
    parameter int TIMER_BITS = DEB_TIMER_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [TIMER_BITS-1:0] term_i,
    output logic                  done_o
);

    logic [TIMER_BITS-1:0] count_q;
    logic [TIMER_BITS-1:0] count_d;

    assign done_o = (count_q == term_i);

    // Next count: clear wins, otherwise advance until the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !done_o) begin
            count_d = count_q + TIMER_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : deb_shared_timer

// File: rtl/debounce_timer_arbiter.sv
// debounce_timer_arbiter: N_CH button debouncers sharing one stability timer.
// Channels whose synchronized level differs from their debounced level are
// served one at a time, round-robin, by a small IDLE/COUNT/COMMIT FSM.
// Optional feature: define DEB_EDGE_PULSE_EN to generate one-cycle
// press_pulse/release_pulse strobes; otherwise those ports read constant 0.

module debounce_timer_arbiter
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TIMER_BITS = DEB_TIMER_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [TIMER_BITS-1:0]   final_value,
    input  logic [N_CH-1:0]         noisy,
    output logic [N_CH-1:0]         debounced,
    output logic                    busy,
    output logic [$clog2(N_CH)-1:0] grant_ch,
    output logic [N_CH-1:0]         press_pulse,
    output logic [N_CH-1:0]         release_pulse
);

    localparam int              CH_W    = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [N_CH-1:0]       sync1_q;
    logic [N_CH-1:0]       sync2_q;
    logic [N_CH-1:0]       deb_q;
    logic [N_CH-1:0]       deb_d;
    logic [CH_W-1:0]       grant_q;
    logic [CH_W-1:0]       grant_d;
    logic [CH_W-1:0]       rr_q;
    logic [CH_W-1:0]       rr_d;
    logic [TIMER_BITS-1:0] fv_q;
    logic [TIMER_BITS-1:0] fv_d;
    deb_state_e            state_q;
    deb_state_e            state_d;
    logic                  busy_q;
    logic                  busy_d;

    logic [N_CH-1:0]       mismatch_s;
    logic [CH_W-1:0]       pick_s;
    logic                  pick_valid_s;
    logic [CH_W-1:0]       grant_next_s;
    logic                  tmr_clear_s;
    logic                  tmr_enable_s;
    logic                  tmr_done_s;

    assign mismatch_s   = sync2_q ^ deb_q;
    assign grant_next_s = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);

    // Two-flop synchronizer for every raw button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= noisy;
            sync2_q <= sync1_q;
        end
    end

    // Round-robin pick: first mismatching channel at or above rr_q, wrapping.
    always_comb begin
        int              cand;
        logic [CH_W-1:0] cand_idx;
        pick_s       = '0;
        pick_valid_s = 1'b0;
        cand         = 0;
        cand_idx     = '0;
        for (int off = 0; off < N_CH; off++) begin
            cand = int'(rr_q) + off;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end else begin
                cand = cand;
            end
            cand_idx = CH_W'(cand);
            if (!pick_valid_s && mismatch_s[cand_idx]) begin
                pick_s       = cand_idx;
                pick_valid_s = 1'b1;
            end else begin
                pick_s       = pick_s;
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // FSM next state, timer control and debounced-level update.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        fv_d         = fv_q;
        deb_d        = deb_q;
        tmr_clear_s  = 1'b0;
        tmr_enable_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    // Terminal value is captured here; later edits wait.
                    grant_d     = pick_s;
                    fv_d        = final_value;
                    tmr_clear_s = 1'b1;
                    state_d     = ST_COUNT;
                end else begin
                    grant_d = '0;
                end
            end
            ST_COUNT: begin
                if (sync2_q[grant_q] == deb_q[grant_q]) begin
                    // Input bounced back: give the timer up, no output change.
                    tmr_clear_s = 1'b1;
                    rr_d        = grant_next_s;
                    grant_d     = '0;
                    state_d     = ST_IDLE;
                end else if (tmr_done_s) begin
                    state_d = ST_COMMIT;
                end else begin
                    tmr_enable_s = 1'b1;
                end
            end
            ST_COMMIT: begin
                deb_d[grant_q] = sync2_q[grant_q];
                rr_d           = grant_next_s;
                grant_d        = '0;
                state_d        = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM, arbitration and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            fv_q    <= '0;
            deb_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            fv_q    <= fv_d;
            deb_q   <= deb_d;
            busy_q  <= busy_d;
        end
    end

    deb_shared_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (tmr_clear_s),
        .enable_i (tmr_enable_s),
        .term_i   (fv_q),
        .done_o   (tmr_done_s)
    );

    assign debounced = deb_q;
    assign busy      = busy_q;
    assign grant_ch  = grant_q;

`ifdef DEB_EDGE_PULSE_EN
    logic [N_CH-1:0] press_q;
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] release_q;
    logic [N_CH-1:0] release_d;

    // Strobe direction of a commit that actually flips the stable level.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        if (state_q == ST_COMMIT) begin
            press_d[grant_q]   = sync2_q[grant_q] & ~deb_q[grant_q];
            release_d[grant_q] = ~sync2_q[grant_q] & deb_q[grant_q];
        end else begin
            press_d   = '0;
            release_d = '0;
        end
    end

    // Strobe registers: high in the cycle the new debounced level appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`else
    assign press_pulse   = '0;
    assign release_pulse = '0;
`endif

endmodule : debounce_timer_arbiter

// File: tb/tb_debounce_timer_arbiter.sv
// tb_debounce_timer_arbiter: self-checking bench for debounce_timer_arbiter.
// Table-driven single-channel trials, randomized trials against an
// arithmetic timing model, and hand-written contention and reset sequences.

module tb_debounce_timer_arbiter;

    localparam int N     = 4;
    localparam int TBITS = 18;
`ifdef DEB_EDGE_PULSE_EN
    localparam int PULSE_ON = 1;
`else
    localparam int PULSE_ON = 0;
`endif

    logic             clk;
    logic             reset;
    logic [TBITS-1:0] final_value;
    logic [N-1:0]     noisy;
    logic [N-1:0]     debounced;
    logic             busy;
    logic [1:0]       grant_ch;
    logic [N-1:0]     press_pulse;
    logic [N-1:0]     release_pulse;

    int n_checks;
    int n_fail;

    debounce_timer_arbiter #(
        .N_CH       (N),
        .TIMER_BITS (TBITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .final_value   (final_value),
        .noisy         (noisy),
        .debounced     (debounced),
        .busy          (busy),
        .grant_ch      (grant_ch),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int fv;
        int w;
        int chg_c;
        int exp_rise;
        int exp_fall;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a level held for w cycles is accepted iff w >= fv+3; it
    // appears fv+5 cycles after the change and leaves fv+5 cycles after
    // the input returns.
    function automatic int model_rise(input int fv, input int w);
        return (w >= fv + 3) ? fv + 5 : 0;
    endfunction

    function automatic int model_fall(input int fv, input int w);
        return (w >= fv + 3) ? w + fv + 5 : 0;
    endfunction

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive channel ch high for w cycles and observe timing; called at #1
    // after a rising edge.
    task automatic run_trial(input string nm, input int ch, input int fv,
                             input int w, input int chg_c,
                             input int exp_rise, input int exp_fall);
        logic [N-1:0] m;
        int rise_c, fall_c, press_n, press_c, rel_n, rel_c, other_err;
        m = N'(1) << ch;
        rise_c = 0; fall_c = 0; press_n = 0; press_c = 0;
        rel_n = 0; rel_c = 0; other_err = 0;
        final_value = TBITS'(fv);
        noisy = noisy | m;
        for (int c = 1; c <= w + fv + 10; c++) begin
            @(posedge clk);
            #1;
            if (rise_c == 0 && (debounced & m) != 0) rise_c = c;
            if (rise_c != 0 && fall_c == 0 && (debounced & m) == 0) fall_c = c;
            if ((press_pulse & m) != 0) begin
                press_n++;
                if (press_c == 0) press_c = c;
            end
            if ((release_pulse & m) != 0) begin
                rel_n++;
                if (rel_c == 0) rel_c = c;
            end
            if ((debounced & ~m) != 0) other_err++;
            if (busy && grant_ch != 2'(ch)) other_err++;
            if (!busy && grant_ch != 2'd0) other_err++;
            if (chg_c != 0 && c == chg_c) final_value = TBITS'(1);
            if (chg_c != 0 && c == chg_c + 3) final_value = TBITS'(fv);
            if (c == w) noisy = noisy & ~m;
        end
        check({nm, "_rise"}, rise_c, exp_rise);
        check({nm, "_fall"}, fall_c, exp_fall);
        check({nm, "_press_n"}, press_n, (exp_rise != 0) ? PULSE_ON : 0);
        check({nm, "_press_c"}, press_c, (exp_rise != 0 && PULSE_ON == 1) ? exp_rise : 0);
        check({nm, "_rel_n"}, rel_n, (exp_rise != 0) ? PULSE_ON : 0);
        check({nm, "_rel_c"}, rel_c, (exp_rise != 0 && PULSE_ON == 1) ? exp_fall : 0);
        check({nm, "_other"}, other_err, 0);
        check({nm, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        int ch, fv, w;
        int r0, r1, r2, g1, g2, g2_c;
        logic prev_busy;

        n_checks = 0;
        n_fail   = 0;

        //          ch  fv  w  chg rise fall
        tbl[0] = '{0, 10, 30, 0, 15, 45};  // long hold, fv=10
        tbl[1] = '{1, 10,  6, 0,  0,  0};  // short glitch rejected
        tbl[2] = '{3,  0, 10, 0,  5, 15};  // final_value = 0
        tbl[3] = '{2,  3,  5, 0,  0,  0};  // one below acceptance
        tbl[4] = '{2,  3,  6, 0,  8, 14};  // exactly at acceptance
        tbl[5] = '{1,  7,  9, 0,  0,  0};  // lost during commit cycle
        tbl[6] = '{1,  7, 10, 0, 12, 22};
        tbl[7] = '{0,  0,  2, 0,  0,  0};
        tbl[8] = '{0,  0,  3, 0,  5,  8};
        tbl[9] = '{0, 10, 30, 3, 15, 45};  // final_value edited mid-COUNT

        reset       = 1'b1;
        noisy       = '0;
        final_value = '0;
        idle_cycles(2);
        check("rst_debounced", int'(debounced), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(grant_ch), 0);
        check("rst_pulses", int'(press_pulse | release_pulse), 0);
        reset = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 10; i++) begin
            run_trial($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].fv, tbl[i].w,
                      tbl[i].chg_c, tbl[i].exp_rise, tbl[i].exp_fall);
        end

        for (int i = 0; i < 25; i++) begin
            ch = int'($urandom_range(0, 3));
            fv = int'($urandom_range(0, 12));
            w  = int'($urandom_range(1, fv + 6));
            run_trial($sformatf("rnd%0d", i), ch, fv, w, 0,
                      model_rise(fv, w), model_fall(fv, w));
        end

        // Contention: ch0 and ch2 rise together, ch0 wins from rr_ptr=0.
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        final_value = TBITS'(5);
        noisy = 4'b0101;
        r0 = 0; r2 = 0; g1 = -1; g2 = -1; g2_c = 0; prev_busy = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (r0 == 0 && debounced[0]) r0 = c;
            if (r2 == 0 && debounced[2]) r2 = c;
            if (busy && !prev_busy) begin
                if (g1 < 0) g1 = int'(grant_ch);
                else if (g2 < 0) begin
                    g2 = int'(grant_ch);
                    g2_c = c;
                end
            end
            prev_busy = busy;
        end
        check("s3_ch0_rise", r0, 10);
        check("s3_grant1", g1, 0);
        check("s3_grant2", g2, 2);
        check("s3_grant2_cycle", g2_c, 11);
        check("s3_ch2_rise", r2, 18);
        noisy = '0;
        idle_cycles(40);
        check("s3_settled", int'(debounced), 0);

        // Wrap: rr_ptr is 3 after ch2 was served last; ch3 beats ch0.
        noisy = 4'b1001;
        g1 = -1; g2 = -1; prev_busy = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) begin
                if (g1 < 0) g1 = int'(grant_ch);
                else if (g2 < 0) g2 = int'(grant_ch);
            end
            prev_busy = busy;
        end
        check("s4_grant1", g1, 3);
        check("s4_grant2", g2, 0);
        check("s4_debounced", int'(debounced), 9);
        noisy = '0;
        idle_cycles(40);
        check("s4_settled", int'(debounced), 0);

        // Reset during COUNT discards the pending update and clears outputs.
        final_value = TBITS'(10);
        noisy = 4'b0001;
        idle_cycles(20);
        check("s5_pre_deb", int'(debounced), 1);
        noisy = 4'b0011;
        idle_cycles(7);
        check("s5_mid_busy", int'(busy), 1);
        check("s5_mid_grant", int'(grant_ch), 1);
        #1 reset = 1'b1;
        #1;
        check("s5_async_deb", int'(debounced), 0);
        check("s5_async_busy", int'(busy), 0);
        check("s5_async_grant", int'(grant_ch), 0);
        check("s5_async_pulse", int'(press_pulse | release_pulse), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        r0 = 0; r1 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (r0 == 0 && debounced[0]) r0 = c;
            if (r1 == 0 && debounced[1]) r1 = c;
        end
        check("s5_ch0_redo", r0, 15);
        check("s5_ch1_redo", r1, 28);
        noisy = '0;
        idle_cycles(60);
        check("s5_settled", int'(debounced), 0);
        check("s5_idle_grant", int'(grant_ch), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_debounce_timer_arbiter
